// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Handshaked multi-cycle data memory for the 16-bit datapath.
//                16-bit words, byte addressed, little-endian. A request is
//                accepted in IDLE. The responder then waits LATENCY cycles,
//                commits at the edge that enters RESP, and holds the response
//                in RESP until the initiator consumes it.
//  Option      : define MEM_BOUNDS_CHECK_EN to flag word indices >= DEPTH_WORDS
//                as errors. Without it, addresses wrap modulo DEPTH_WORDS.
//  Ports       : CLK, RESET          - clock, async active-high reset
//                req_valid/req_ready - request handshake
//                req_we, req_byte    - store/load, byte/word
//                req_addr, req_wdata - byte address, store data
//                rsp_valid/rsp_ready - response handshake
//                rsp_rdata, rsp_err  - load data, misalignment/bounds error
//                access_count        - completed transactions (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] access_count
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  c_LATENCY = 4'(LATENCY);
    localparam logic [15:0] c_DEPTH   = 16'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_byte;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_mem [DEPTH_WORDS];
    logic [15:0] r_rdata;
    logic        r_err;
    logic [15:0] r_count;

    logic        w_accept;
    logic        w_commit;
    logic        w_c_we;
    logic        w_c_byte;
    logic [15:0] w_c_addr;
    logic [15:0] w_c_wdata;
    logic [14:0] w_c_word;
    logic [IDX_W-1:0] w_idx;
    logic        w_misalign;
    logic        w_oob;
    logic        w_err;
    logic [15:0] w_cur;
    logic [7:0]  w_lane;
    logic [15:0] w_load_data;

    assign req_ready    = (r_state == S_IDLE) && !RESET;
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;
    assign access_count = r_count;

    assign w_accept = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge itself,
    // so the commit path must see the live request inputs in that case.
    assign w_commit = ((r_state == S_IDLE) && w_accept && (c_LATENCY == 4'd0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd0));

    assign w_c_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_c_byte  = (r_state == S_IDLE) ? req_byte  : r_byte;
    assign w_c_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_c_word   = w_c_addr[15:1];
    assign w_idx      = w_c_word[IDX_W-1:0];
    assign w_misalign = !w_c_byte && w_c_addr[0];
    assign w_oob      = ({1'b0, w_c_word} >= c_DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_err = w_misalign || w_oob;
`else
    logic w_unused_oob;
    assign w_unused_oob = w_oob;
    assign w_err        = w_misalign;
`endif

    assign w_cur  = r_mem[w_idx];
    assign w_lane = w_c_addr[0] ? w_cur[15:8] : w_cur[7:0];

    always_comb begin
        w_load_data = 16'h0000;
        if (!w_err && !w_c_we) begin
            w_load_data = w_c_byte ? {8'h00, w_lane} : w_cur;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (c_LATENCY == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter is loaded with LATENCY and counts down to zero; the edge after
    // it reaches zero commits, giving a response LATENCY+1 edges after accept.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_LATENCY;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_byte  <= req_byte;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Storage: byte stores touch only the lane picked by addr[0]
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (w_commit && w_c_we && !w_err) begin
            if (w_c_byte) begin
                if (w_c_addr[0]) begin
                    r_mem[w_idx][15:8] <= w_c_wdata[7:0];
                end else begin
                    r_mem[w_idx][7:0]  <= w_c_wdata[7:0];
                end
            end else begin
                r_mem[w_idx] <= w_c_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers and transaction counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rdata <= 16'h0000;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_rdata <= w_load_data;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= 16'h0000;
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_count <= r_count + 16'h0001;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. A word-array
//                reference model predicts load data, error flag, response
//                latency and transaction count for directed and random
//                requests. Honours MEM_BOUNDS_CHECK_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int c_DEPTH = 128;
    localparam int c_LAT   = 2;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] access_count;

    int n_pass;
    int n_total;

    logic [15:0] m_mem [c_DEPTH];
    logic [15:0] m_count;

    data_mem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .LATENCY     (c_LAT)
    ) u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_byte     (req_byte),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .access_count (access_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 16'h0000;
        m_count = 16'h0000;
    endtask

    // One complete transaction; hold = cycles of response backpressure.
    task automatic txn(input logic we, input logic bt, input logic [15:0] addr,
                       input logic [15:0] wd, input int hold);
        int          widx;
        int          edges;
        logic        mis;
        logic        oob;
        logic        err;
        logic [15:0] cur;
        logic [15:0] er;

        widx = int'(addr >> 1) % c_DEPTH;
        mis  = !bt && addr[0];
        oob  = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        oob  = int'(addr >> 1) >= c_DEPTH;
`endif
        err  = mis || oob;
        cur  = m_mem[widx];
        if (err || we)  er = 16'h0000;
        else if (bt)    er = addr[0] ? (cur >> 8) : (cur & 16'h00FF);
        else            er = cur;
        if (we && !err) begin
            if (bt) m_mem[widx] = addr[0] ? ((cur & 16'h00FF) | {wd[7:0], 8'h00})
                                          : ((cur & 16'hFF00) | {8'h00, wd[7:0]});
            else    m_mem[widx] = wd;
        end

        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = 1'b0;
        @(posedge CLK); #1;
        // scramble request inputs; they must not affect the accepted txn
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_byte  = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);

        edges = 0;
        while (!rsp_valid && edges < 40) begin
            req_valid = 1'($urandom);
            @(posedge CLK); #1;
            edges++;
        end
        req_valid = 1'b0;
        check("rsp_latency", 32'(edges), 32'(c_LAT + 1));
        check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, er});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, err});
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        check("count_hold", {16'd0, access_count}, {16'd0, m_count});

        for (int k = 0; k < hold; k++) begin
            req_valid = 1'($urandom);
            @(posedge CLK); #1;
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rdata", {16'd0, rsp_rdata}, {16'd0, er});
            check("bp_ready", {31'd0, req_ready}, 32'd0);
            check("bp_count", {16'd0, access_count}, {16'd0, m_count});
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        m_count   = m_count + 16'd1;
        check("rsp_done", {31'd0, rsp_valid}, 32'd0);
        check("count_done", {16'd0, access_count}, {16'd0, m_count});
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        RESET     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        model_reset();

        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_count", {16'd0, access_count}, 32'd0);
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b0;
        @(posedge CLK); #1;

        // word store/load
        txn(1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
        check("plan_beef", {16'd0, rsp_rdata}, 32'h0000_BEEF);
        check("plan_count2", {16'd0, access_count}, 32'd2);

        // byte lanes
        txn(1'b1, 1'b0, 16'h0020, 16'h1234, 0);
        txn(1'b1, 1'b1, 16'h0021, 16'h00AB, 1);
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 0);
        check("plan_ab34", {16'd0, rsp_rdata}, 32'h0000_AB34);
        txn(1'b0, 1'b1, 16'h0020, 16'h0000, 0);
        check("plan_0034", {16'd0, rsp_rdata}, 32'h0000_0034);

        // misaligned word store, then the aligned word is untouched
        txn(1'b1, 1'b0, 16'h0031, 16'h5555, 0);
        txn(1'b0, 1'b0, 16'h0030, 16'h0000, 0);
        check("plan_misalign", {16'd0, rsp_rdata}, 32'h0000_0000);

        // backpressure on a load
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 5);

        // alias / bounds at 0x0100
        txn(1'b1, 1'b0, 16'h0100, 16'h7777, 0);
        txn(1'b0, 1'b0, 16'h0000, 16'h0000, 0);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            logic [15:0] a;
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            else                           a = 16'($urandom_range(0, 255));
            txn(1'($urandom), 1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)));
        end

        // reset in the middle of a store's wait phase
        check("pre_rst_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h0040;
        req_wdata = 16'hCAFE;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        #1;
        model_reset();
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_count", {16'd0, access_count}, 32'd0);
        check("mid_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("mid_rst_err", {31'd0, rsp_err}, 32'd0);
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b0;
        @(posedge CLK); #1;
        txn(1'b0, 1'b0, 16'h0040, 16'h0000, 0);
        check("post_rst_load", {16'd0, rsp_rdata}, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
